// File: rtl/sdram_init_seq.sv
// Power-up initialization sequencer for a 16-bit SDR SDRAM: power-up wait, PRECHARGE ALL,
// AR_NUM AUTO REFRESH, LOAD MODE, then sticky init_end. Define SDRAM_INIT_SIM_EN for a 200-clock power-up wait.
module sdram_init_seq #(
   parameter int          T_POWER  = 20000,
   parameter int          T_RP     = 2,
   parameter int          T_RFC    = 7,
   parameter int          T_MRD    = 3,
   parameter int          AR_NUM   = 8,
   parameter logic [12:0] MODE_VAL = 13'h0037
) (
   input  logic        init_clk,
   input  logic        init_rst,
   output logic [3:0]  init_cmd,
   output logic [1:0]  init_bank,
   output logic [12:0] init_addr,
   output logic        init_end
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   // The wait counter reads 0 in the reset clock, so WAIT leaves once it reaches the full count.
`ifdef SDRAM_INIT_SIM_EN
   localparam logic [14:0] WAIT_LAST = 15'd200;
`else
   localparam logic [14:0] WAIT_LAST = 15'(T_POWER);
`endif
   localparam logic [14:0] TRP_LAST  = 15'(T_RP - 1);
   localparam logic [14:0] TRFC_LAST = 15'(T_RFC - 1);
   localparam logic [14:0] TMRD_LAST = 15'(T_MRD - 1);
   localparam logic [3:0]  AR_TOTAL  = 4'(AR_NUM);

   typedef enum logic [2:0] {
      ST_WAIT = 3'b000,
      ST_PRE  = 3'b001,
      ST_TRP  = 3'b011,
      ST_AR   = 3'b010,
      ST_TRFC = 3'b110,
      ST_MRS  = 3'b111,
      ST_TMRD = 3'b101,
      ST_END  = 3'b100
   } state_t;

   state_t      state_curr;
   state_t      state_next_s;
   logic [14:0] wait_cnt_r;
   logic [3:0]  ar_cnt_r;
   logic [3:0]  cmd_s;
   logic [1:0]  bank_s;
   logic [12:0] addr_s;

   // State register
   always_ff @(posedge init_clk) begin
      if (init_rst) begin
         state_curr <= ST_WAIT;
      end else begin
         state_curr <= state_next_s;
      end
   end

   // Shared wait counter restarts on every state change; refresh counter clears only in reset
   always_ff @(posedge init_clk) begin
      if (init_rst) begin
         wait_cnt_r <= 15'd0;
         ar_cnt_r   <= 4'd0;
      end else begin
         if (state_next_s != state_curr) begin
            wait_cnt_r <= 15'd0;
         end else begin
            wait_cnt_r <= wait_cnt_r + 15'd1;
         end
         if (state_curr == ST_AR) begin
            ar_cnt_r <= ar_cnt_r + 4'd1;
         end else begin
            ar_cnt_r <= ar_cnt_r;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_curr;
      case (state_curr)
         ST_WAIT: if (wait_cnt_r == WAIT_LAST) state_next_s = ST_PRE; else state_next_s = ST_WAIT;
         ST_PRE:  state_next_s = ST_TRP;
         ST_TRP:  if (wait_cnt_r == TRP_LAST) state_next_s = ST_AR; else state_next_s = ST_TRP;
         ST_AR:   state_next_s = ST_TRFC;
         ST_TRFC: begin
            if (wait_cnt_r == TRFC_LAST) begin
               if (ar_cnt_r == AR_TOTAL) state_next_s = ST_MRS;
               else                      state_next_s = ST_AR;
            end else begin
               state_next_s = ST_TRFC;
            end
         end
         ST_MRS:  state_next_s = ST_TMRD;
         ST_TMRD: if (wait_cnt_r == TMRD_LAST) state_next_s = ST_END; else state_next_s = ST_TMRD;
         ST_END:  state_next_s = ST_END;
         default: state_next_s = ST_WAIT;
      endcase
   end

   // Command decode of the upcoming state so the registered outputs line up with state_curr
   always_comb begin
      cmd_s  = CMD_NOP;
      bank_s = 2'b11;
      addr_s = 13'h1FFF;
      case (state_next_s)
         ST_PRE: begin
            cmd_s  = CMD_PRE;
            addr_s = 13'h0400;
         end
         ST_AR:  cmd_s = CMD_AR;
         ST_MRS: begin
            cmd_s  = CMD_MRS;
            bank_s = 2'b00;
            addr_s = MODE_VAL;
         end
         default: begin
            cmd_s  = CMD_NOP;
            bank_s = 2'b11;
            addr_s = 13'h1FFF;
         end
      endcase
   end

   // Registered command bus and completion flag
   always_ff @(posedge init_clk) begin
      if (init_rst) begin
         init_cmd  <= CMD_NOP;
         init_bank <= 2'b11;
         init_addr <= 13'h1FFF;
         init_end  <= 1'b0;
      end else begin
         init_cmd  <= cmd_s;
         init_bank <= bank_s;
         init_addr <= addr_s;
         init_end  <= (state_next_s == ST_END);
      end
   end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: per-cycle comparison against a schedule-arithmetic
// reference model, with directed and randomly placed resets.
module tb_sdram_init_seq;

   localparam int          TP     = 200;
   localparam int          T_RP   = 2;
   localparam int          T_RFC  = 7;
   localparam int          T_MRD  = 3;
   localparam int          AR_NUM = 8;
   localparam logic [12:0] MV     = 13'h0037;
   localparam int          AR_T   = 1 + T_RFC;
   localparam int          END_C  = TP + 1 + T_RP + AR_NUM * AR_T + 1 + T_MRD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  init_cmd;
   logic [1:0]  init_bank;
   logic [12:0] init_addr;
   logic        init_end;

   int tests   = 0;
   int fails   = 0;
   int c       = -1;
   int ar_seen = 0;

   always #5 clk = ~clk;

   sdram_init_seq #(
      .T_POWER (TP),
      .T_RP    (T_RP),
      .T_RFC   (T_RFC),
      .T_MRD   (T_MRD),
      .AR_NUM  (AR_NUM),
      .MODE_VAL(MV)
   ) dut (
      .init_clk (clk),
      .init_rst (rst),
      .init_cmd (init_cmd),
      .init_bank(init_bank),
      .init_addr(init_addr),
      .init_end (init_end)
   );

   // Reference: what the bus and state should show c cycles after reset release (c = -1 is a reset clock).
   task automatic model(input int cyc, output logic [3:0] cmd, output logic [1:0] bank,
                        output logic [12:0] addr, output logic done, output logic [2:0] st);
      int t;
      int m;
      cmd  = 4'b0111;
      bank = 2'b11;
      addr = 13'h1FFF;
      done = 1'b0;
      t    = cyc - TP - 1 - T_RP;
      m    = t - AR_NUM * AR_T;
      if (cyc < TP) begin
         st = 3'b000;
      end else if (cyc == TP) begin
         st = 3'b001; cmd = 4'b0010; addr = 13'h0400;
      end else if (t < 0) begin
         st = 3'b011;
      end else if (m < 0) begin
         if (t % AR_T == 0) begin st = 3'b010; cmd = 4'b0001; end
         else st = 3'b110;
      end else if (m == 0) begin
         st = 3'b111; cmd = 4'b0000; bank = 2'b00; addr = MV;
      end else if (m <= T_MRD) begin
         st = 3'b101;
      end else begin
         st = 3'b100; done = 1'b1;
      end
   endtask

   task automatic check();
      logic [3:0]  ecmd;
      logic [1:0]  ebank;
      logic [12:0] eaddr;
      logic        eend;
      logic [2:0]  est;
      model(c, ecmd, ebank, eaddr, eend, est);
      tests++;
      assert (init_cmd === ecmd) else begin
         fails++; $error("FAIL cmd c=%0d got %b expected %b", c, init_cmd, ecmd);
      end
      tests++;
      assert (init_addr === eaddr) else begin
         fails++; $error("FAIL addr c=%0d got %h expected %h", c, init_addr, eaddr);
      end
      tests++;
      assert (init_bank === ebank) else begin
         fails++; $error("FAIL bank c=%0d got %b expected %b", c, init_bank, ebank);
      end
      tests++;
      assert (init_end === eend) else begin
         fails++; $error("FAIL init_end c=%0d got %b expected %b", c, init_end, eend);
      end
      tests++;
      assert (dut.state_curr === est) else begin
         fails++; $error("FAIL state c=%0d got %b expected %b", c, dut.state_curr, est);
      end
      if (c == -1) ar_seen = 0;
      else if (init_cmd === 4'b0001) ar_seen++;
      if (c == END_C) begin
         tests++;
         assert (ar_seen === AR_NUM) else begin
            fails++; $error("FAIL ar_count got %0d expected %0d", ar_seen, AR_NUM);
         end
      end
   endtask

   task automatic run(input int n, input logic r);
      for (int i = 0; i < n; i++) begin
         rst = r;
         @(posedge clk);
         c = r ? -1 : c + 1;
         @(negedge clk);
         check();
      end
   endtask

   initial begin
      run(2, 1'b1);
      run(END_C + 10, 1'b0);
      run(1, 1'b1);
      run(231, 1'b0);
      run(1, 1'b1);
      run(END_C + 10, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run(int'($urandom_range(0, END_C + 20)), 1'b0);
         run(int'($urandom_range(1, 3)), 1'b1);
      end
      run(END_C + 20, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

Power-up initialization sequencer for a 16-bit SDR SDRAM (W989DxDB-class device) at 100 MHz. After reset it waits the power-up interval, issues PRECHARGE ALL, eight AUTO REFRESH commands and a LOAD MODE REGISTER, honouring tRP/tRFC/tMRD with NOPs, then raises `init_end`. It sits in front of the SDRAM command mux; the arbiter hands the bus to normal traffic only after `init_end`.

## Interface
- `T_POWER`, 20000: power-up wait in clocks (200 us at 10 ns).
- `T_RP`, 2: NOP clocks after PRECHARGE.
- `T_RFC`, 7: NOP clocks after each AUTO REFRESH.
- `T_MRD`, 3: NOP clocks after LOAD MODE.
- `AR_NUM`, 8: number of AUTO REFRESH commands.
- `MODE_VAL`, 13'h0037: mode word. Write burst = burst, CAS latency = 3, sequential, full-page burst.

Ports:
- `init_clk`, in, 1: clock, 100 MHz.
- `init_rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `init_cmd`, out, 4: {cs_n, ras_n, cas_n, we_n}.
- `init_bank`, out, 2: bank address.
- `init_addr`, out, 13: address bus.
- `init_end`, out, 1: initialization complete; level, sticky until reset.

## Operation
- Command encodings:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
  - LOAD MODE = 4'b0000
- States are Gray-coded, 3 bits, held in register `state_curr`:
  - WAIT = 000
  - PRE = 001
  - TRP = 011
  - AR = 010
  - TRFC = 110
  - MRS = 111
  - TMRD = 101
  - END = 100
- Transitions:
  - WAIT → PRE after T_POWER clocks in WAIT.
  - PRE → TRP after 1 clock.
  - TRP → AR after T_RP clocks.
  - AR → TRFC after 1 clock; the refresh counter increments.
  - TRFC → MRS after T_RFC clocks if refresh count == AR_NUM, else TRFC → AR.
  - MRS → TMRD after 1 clock.
  - TMRD → END after T_MRD clocks.
  - END is absorbing.
- One shared wait counter clears on every state change; the refresh counter clears in reset only. Counters are 15 bits wide and 4 bits wide respectively.
- Outputs are Moore, decoded from `state_curr`:
  - PRE: PRECHARGE, addr = 13'h0400 (A10 = 1, all banks), bank = 2'b11.
  - AR: AUTO REFRESH, addr = 13'h1FFF, bank = 2'b11.
  - MRS: LOAD MODE, addr = MODE_VAL, bank = 2'b00.
  - All other states: NOP, addr = 13'h1FFF, bank = 2'b11.
- `init_end` = 1 only in END.
- Unreachable encodings decode as NOP and return to WAIT on the next clock.

## Timing
- Reset values:
  - state = WAIT, counters = 0
  - `init_cmd` = 4'b0111, `init_bank` = 2'b11, `init_addr` = 13'h1FFF, `init_end` = 0
- With cycle 0 = first clock after `init_rst` is sampled low:
  - PRE at cycle T_POWER.
  - First AR at T_POWER+1+T_RP.
  - AR k (k = 0..7) at T_POWER+1+T_RP+k·(1+T_RFC).
  - MRS at T_POWER+1+T_RP+AR_NUM·(1+T_RFC).
  - `init_end` rises at MRS+1+T_MRD. With defaults this is cycle 20071.
- Each non-NOP command lasts exactly one clock.
- Reset asserted mid-sequence or in END:
  - Next clock returns to WAIT with NOP and clears counters.
  - `init_end` drops in the same clock.
  - The full sequence restarts.

## Configuration
- `SDRAM_INIT_SIM_EN`:
  - Defined: power-up wait is forced to 200 clocks regardless of T_POWER, for fast simulation; `init_end` then rises at cycle 271.
  - Undefined: T_POWER is used as given.
  - All other timing is identical in both cases.

## Test plan
- Reset release, macro defined: NOP until cycle 200, PRECHARGE with addr 13'h0400 at cycle 200, NOP cycles 201–202.
- Refresh train: exactly 8 AUTO REFRESH pulses at cycles 203, 211, …, 259, each one clock, NOP between.
- Mode load: LOAD MODE at cycle 267 with addr 13'h0037 and bank 00; `init_end` = 1 from cycle 271 onward, NOP held.
- State trace: `state_curr` visits 000→001→011→(010→110)×8→111→101→100 with no other codes.
- Reset at cycle 230 (mid refresh train): next cycle outputs NOP and `init_end` = 0; after release the full 271-cycle sequence repeats with 8 fresh refreshes.
- Memory model hookup (cke = 1, dqm = 0): model reports no timing violations and accepts mode CL = 3, full-page burst.
